// File: rtl/fifo_uram_pkg.sv
// Shared sizing helpers for the URAM-backed show-ahead FIFO controller.
// Holds the capacity derivation, occupancy width and the pointer wrap-increment.
package fifo_uram_pkg;

    // RAM depth plus the two output-buffer slots.
    function automatic int cap_of(input int address_range);
        return address_range + 2;
    endfunction

    // Wide enough to hold CAP for any ADDRESS_RANGE <= 2**ADDRESS_WIDTH.
    function automatic int occ_width(input int address_width);
        return address_width + 2;
    endfunction

    // Depth need not be a power of two, so the wrap is explicit.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned range);
        return (ptr == range - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_uram_ctrl_obuf.sv
// Two-entry output buffer that hides the one-cycle RAM read latency.
// The head register drives the show-ahead data output directly.
module fifo_uram_ctrl_obuf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_cap_valid,
    input  logic [DATA_WIDTH-1:0] i_cap_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_cnt
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else if (i_cap_valid && i_pop) begin
            // Count unchanged; the new word goes behind whatever remains.
            if (r_cnt == 2'd2) begin
                r_head <= r_tail;
                r_tail <= i_cap_data;
            end else begin
                r_head <= i_cap_data;
            end
        end else if (i_cap_valid) begin
            if (r_cnt == 2'd0) begin
                r_head <= i_cap_data;
            end else begin
                r_tail <= i_cap_data;
            end
            r_cnt <= r_cnt + 2'd1;
        end else if (i_pop) begin
            if (r_cnt == 2'd2) begin
                r_head <= r_tail;
            end
            r_cnt <= r_cnt - 2'd1;
        end
    end

    assign o_head = r_head;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_uram_ctrl.sv
// Show-ahead FIFO controller sequencing an external simple dual-port URAM.
// Optional occupancy port if_level is enabled by defining FIFO_URAM_CTRL_LEVEL_EN.
module fifo_uram_ctrl
    import fifo_uram_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6,
    parameter int ADDRESS_RANGE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    if_din,
    input  logic                     if_write,
    output logic                     if_full_n,
    output logic [DATA_WIDTH-1:0]    if_dout,
    input  logic                     if_read,
    output logic                     if_empty_n,
    output logic [ADDRESS_WIDTH-1:0] mem_address0,
    output logic                     mem_ce0,
    output logic                     mem_we0,
    output logic [DATA_WIDTH-1:0]    mem_d0,
    output logic [ADDRESS_WIDTH-1:0] mem_address1,
    output logic                     mem_ce1,
    input  logic [DATA_WIDTH-1:0]    mem_q1
`ifdef FIFO_URAM_CTRL_LEVEL_EN
   ,output logic [ADDRESS_WIDTH+1:0] if_level
`endif
);

    localparam int              OCC_W = occ_width(ADDRESS_WIDTH);
    localparam logic [OCC_W-1:0] CAP  = OCC_W'(cap_of(ADDRESS_RANGE));
    localparam int unsigned     RANGE = ADDRESS_RANGE;

    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [OCC_W-1:0]         r_ram_cnt;
    logic                     r_inflight;
    logic                     r_full_n;
    logic                     r_empty_n;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_issue;
    logic [1:0]               w_ob_cnt;
    logic [2:0]               w_ob_pending;
    logic [1:0]               w_ob_cnt_next;
    logic [OCC_W-1:0]         w_ram_cnt_next;
    logic [OCC_W-1:0]         w_occ_next;

    assign w_push = if_write && r_full_n;
    assign w_pop  = if_read && r_empty_n;

    // Prefetch whenever the buffer plus the read in flight, net of this pop, has room.
    assign w_ob_pending = {1'b0, w_ob_cnt} + {2'b00, r_inflight};
    assign w_issue      = (r_ram_cnt != '0) && (w_ob_pending < (3'd2 + {2'b00, w_pop}));

    assign w_ob_cnt_next  = w_ob_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_ram_cnt_next = r_ram_cnt + OCC_W'(w_push) - OCC_W'(w_issue);
    assign w_occ_next     = w_ram_cnt_next + OCC_W'(w_issue) + OCC_W'(w_ob_cnt_next);

    fifo_uram_ctrl_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .srst        (reset),
        .i_cap_valid (r_inflight),
        .i_cap_data  (mem_q1),
        .i_pop       (w_pop),
        .o_head      (if_dout),
        .o_cnt       (w_ob_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_full_n   <= 1'b1;
            r_empty_n  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ADDRESS_WIDTH'(ptr_inc(32'(r_wr_ptr), RANGE));
            end
            if (w_issue) begin
                r_rd_ptr <= ADDRESS_WIDTH'(ptr_inc(32'(r_rd_ptr), RANGE));
            end
            r_ram_cnt  <= w_ram_cnt_next;
            r_inflight <= w_issue;
            r_full_n   <= (w_occ_next != CAP);
            r_empty_n  <= (w_ob_cnt_next != 2'd0);
        end
    end

`ifdef FIFO_URAM_CTRL_LEVEL_EN
    logic [OCC_W-1:0] r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= w_occ_next;
        end
    end

    assign if_level = r_level;
`endif

    assign if_full_n    = r_full_n;
    assign if_empty_n   = r_empty_n;
    assign mem_address0 = r_wr_ptr;
    assign mem_ce0      = w_push && !reset;
    assign mem_we0      = w_push && !reset;
    assign mem_d0       = if_din;
    assign mem_address1 = r_rd_ptr;
    assign mem_ce1      = w_issue && !reset;

endmodule

// File: tb/tb_fifo_uram_ctrl.sv
// Scoreboard bench for fifo_uram_ctrl with a behavioural URAM model.
// Uses a 48-word, non-power-of-two depth so pointer wrap is exercised.
module tb_fifo_uram_ctrl;

    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int AR  = 48;
    localparam int CAP = AR + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] if_din = '0;
    logic          if_write = 1'b0;
    logic          if_read = 1'b0;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW-1:0] mem_address0;
    logic          mem_ce0;
    logic          mem_we0;
    logic [DW-1:0] mem_d0;
    logic [AW-1:0] mem_address1;
    logic          mem_ce1;
    logic [DW-1:0] mem_q1 = '0;
`ifdef FIFO_URAM_CTRL_LEVEL_EN
    logic [AW+1:0] if_level;
`endif

    always #5 clk = ~clk;

    fifo_uram_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .ADDRESS_RANGE (AR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_din       (if_din),
        .if_write     (if_write),
        .if_full_n    (if_full_n),
        .if_dout      (if_dout),
        .if_read      (if_read),
        .if_empty_n   (if_empty_n),
        .mem_address0 (mem_address0),
        .mem_ce0      (mem_ce0),
        .mem_we0      (mem_we0),
        .mem_d0       (mem_d0),
        .mem_address1 (mem_address1),
        .mem_ce1      (mem_ce1),
        .mem_q1       (mem_q1)
`ifdef FIFO_URAM_CTRL_LEVEL_EN
       ,.if_level     (if_level)
`endif
    );

    // Simple dual-port RAM: write port 0, registered read port 1.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) ram[mem_address0] <= mem_d0;
        if (mem_ce1) mem_q1 <= ram[mem_address1];
    end

    typedef struct {
        logic [DW-1:0] data;
        int            pcyc;
    } entry_t;

    entry_t     exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         pop_total = 0;
    logic       exp_push = 1'b0;
    int         exp_waddr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: RAM-port legality, show-ahead latency and data order.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("ce_in_reset", {61'd0, mem_ce0, mem_we0, mem_ce1}, 64'd0);
            end else begin
                check("we0", mem_we0, exp_push);
                check("ce0", mem_ce0, exp_push);
                if (exp_push) begin
                    check("waddr", mem_address0, exp_waddr);
                    check("wdata", mem_d0, if_din);
                end
                if (mem_ce1) begin
                    check("raddr", mem_address1, rd_cnt % AR);
                    rd_cnt++;
                end
                if (exp_q.size() == 0) begin
                    check("empty_n_idle", if_empty_n, 1'b0);
                end else begin
                    check("empty_n_age", if_empty_n, (cyc >= exp_q[0].pcyc + 3));
                end
                if (if_read && if_empty_n) begin
                    pop_total++;
                    if (exp_q.size() == 0) begin
                        check("pop_unexpected", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dout", if_dout, e.data);
                    end
                end
            end
        end
    end

    // Called just after a rising edge; drives one cycle and returns after the next edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        check("full_n", if_full_n, (exp_q.size() != CAP));
`ifdef FIFO_URAM_CTRL_LEVEL_EN
        check("level", if_level, exp_q.size());
`endif
        if_write = w;
        if_din   = d;
        if_read  = r;
        exp_push = w && (exp_q.size() != CAP);
        if (exp_push) begin
            exp_waddr = wr_cnt % AR;
            wr_cnt++;
            exp_q.push_back(entry_t'{data: d, pcyc: cyc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        if_write = 1'b0;
        if_read  = 1'b0;
        reset    = 1'b1;
        exp_push = 1'b0;
        exp_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        do_reset(3);
        check("rst_full_n", if_full_n, 1'b1);
        check("rst_empty_n", if_empty_n, 1'b0);
        check("rst_dout", if_dout, '0);
        check("rst_ce1", mem_ce1, 1'b0);

        // Single word: issue in cycle 1, visible in cycle 3.
        step(1'b1, 32'hA5, 1'b0);
        check("ce1_cycle1", mem_ce1, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("empty_n_cycle2_end", if_empty_n, 1'b1);
        check("dout_a5", if_dout, 32'hA5);
        drain();

        // Fill to capacity, one dropped push, then write+read at full.
        for (int i = 0; i < CAP; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 32'hDEAD, 1'b0);
        step(1'b1, 32'hBEEF, 1'b1);
        check("after_full_pop_cnt", exp_q.size(), CAP - 1);
        drain();

        // Random push/pop traffic.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0);
        end
        drain();

        // Continuous streaming across several pointer wraps.
        p0 = pop_total;
        for (int i = 0; i < 200; i++) step(1'b1, DW'(i + 1000), 1'b1);
        check("stream_pops", pop_total - p0, 197);
        drain();

        // Reset while a read is in flight.
        do_reset(2);
        step(1'b1, 32'h77, 1'b0);
        check("ce1_before_reset", mem_ce1, 1'b1);
        step(1'b0, '0, 1'b0);
        do_reset(1);
        check("rst_inflight_empty_n", if_empty_n, 1'b0);
        check("rst_inflight_full_n", if_full_n, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_uram_ctrl.md
# fifo_uram_ctrl

Show-ahead FIFO controller that sequences an external simple dual-port URAM memory core: write port 0, read port 1, one-cycle registered read latency. It turns a stream push/pop interface into RAM writes and prefetch reads. A 2-entry output buffer hides the RAM read latency, so full throughput is sustained. It sits between a task's stream producer and consumer wherever a deep stream is mapped to URAM.

## Interface
- DATA_WIDTH, 32, stream word width; equals the memory data width.
- ADDRESS_WIDTH, 6, memory address width.
- ADDRESS_RANGE, 64, memory depth in words; ≤ 2^ADDRESS_WIDTH; need not be a power of two.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset; synchronous, active-high.
- if_din  in  DATA_WIDTH  push data.
- if_write  in  1  push request.
- if_full_n  out  1  not-full; push accepted when if_write && if_full_n.
- if_dout  out  DATA_WIDTH  head word (show-ahead).
- if_read  in  1  pop request.
- if_empty_n  out  1  not-empty; pop accepted when if_read && if_empty_n.
- mem_address0  out  ADDRESS_WIDTH  RAM write address.
- mem_ce0 / mem_we0  out  1 each  RAM write enables; both equal the push-accept signal.
- mem_d0  out  DATA_WIDTH  RAM write data; equals if_din.
- mem_address1  out  ADDRESS_WIDTH  RAM read address.
- mem_ce1  out  1  RAM read issue.
- mem_q1  in  DATA_WIDTH  RAM read data; valid the cycle after mem_ce1.
- if_level  out  ADDRESS_WIDTH+2  occupancy; present only with FIFO_URAM_CTRL_LEVEL_EN.

## Operation
- State:
  - wr_ptr and rd_ptr over [0, ADDRESS_RANGE-1]; each wraps from ADDRESS_RANGE-1 to 0 explicitly.
  - ram_cnt: words resident in RAM.
  - inflight (0/1): read issued last cycle.
  - ob_cnt (0..2): words in the output buffer.
  - occ = ram_cnt + inflight + ob_cnt.
- Capacity CAP = ADDRESS_RANGE + 2.
- push = if_write && if_full_n. A push drives mem_ce0/we0 at wr_ptr, advances wr_ptr and increments ram_cnt.
- pop = if_read && if_empty_n. A pop removes the buffer head.
- Read issue: mem_ce1 = ram_cnt != 0 && (ob_cnt + inflight − pop) < 2, at address rd_ptr. An issue advances rd_ptr, decrements ram_cnt and sets inflight for the next cycle.
- When inflight is set, mem_q1 is written into the buffer tail that cycle.
- If capture and pop happen in the same cycle, ob_cnt is unchanged and order is preserved.
- Push and read issue in the same cycle update ram_cnt by net 0.
- A write to address A in cycle t is visible to a read of A in cycle t+1 or later. A read is never issued to a word pushed in the same cycle.
- Push while !if_full_n is ignored: no RAM write, no state change. Pop while !if_empty_n is ignored.
- At full, with if_write and if_read both high, only the pop is accepted.
- With no push and no pop, state is stable. Any pending prefetch completes.

## Timing
- Reset values:
  - if_full_n = 1, if_empty_n = 0.
  - Pointers, counters and inflight are 0; if_dout = 0; if_level = 0.
  - mem_ce0, mem_we0 and mem_ce1 are forced 0 while reset is high.
- if_full_n and if_empty_n are registered: if_full_n = (occ_next != CAP), if_empty_n = (ob_cnt_next != 0). if_dout is registered.
- Reset mid-operation discards all contents, including an in-flight read; RAM contents are don't-care.
- Push in cycle 0 into an empty FIFO:
  - mem_ce1 in cycle 1.
  - mem_q1 captured at the end of cycle 2.
  - if_empty_n = 1 and if_dout valid in cycle 3.
  - Write-to-read latency is therefore 3 cycles.
- Steady state: with continuous push and pop, 1 word/cycle in each direction with no bubbles.
- Push-accept to if_full_n deassert: 1 cycle.
- Pop that empties the buffer: if_empty_n = 0 next cycle.

## Configuration
- FIFO_URAM_CTRL_LEVEL_EN defined: the if_level port exists and is registered. It equals occ after each edge and is 0 in reset.
- FIFO_URAM_CTRL_LEVEL_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package fifo_uram_pkg holds:
  - the CAP derivation;
  - the occupancy width (ADDRESS_WIDTH+2);
  - the pointer wrap-increment function.
- Sub-module fifo_uram_ctrl_obuf: the 2-entry output buffer.
  - Inputs: capture valid/data, pop.
  - Outputs: registered head, ob_cnt.
  - Pointer and counter logic stays in the top.

## Test plan
- Reset, then single push 0xA5 in cycle 0 → mem_ce1 in cycle 1; if_empty_n = 1 and if_dout = 0xA5 in cycle 3.
- Push 66 words (ADDRESS_RANGE 64) with no pops → if_full_n = 0 after the 66th, with no further mem_we0. The 67th push is ignored. Draining returns words 0..65 in order.
- Continuous push/pop for 1000 cycles with a random pattern → 1 word/cycle sustained after fill, with the scoreboard matching.
- ADDRESS_RANGE = 48 with 200 streamed words → pointers wrap 47→0 and data order is intact.
- At full, if_write = if_read = 1 → pop accepted, push dropped, occ = 65.
- Reset asserted while mem_ce1 is in flight → next cycle if_empty_n = 0, if_full_n = 1, stale mem_q1 not captured; with FIFO_URAM_CTRL_LEVEL_EN, if_level = 0.
